// File: rtl/div_unit_pkg.sv
// Shared definitions for the integer divide unit: operation encodings,
// FSM state encodings and small decode helpers used by the unit and by
// the instruction decoder.
package div_unit_pkg;

  localparam int DEFAULT_XLEN = 32;

  // div_op encodings: bit 1 selects remainder, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPUTE = 2'b01,
    S_DONE    = 2'b10
  } div_state_e;

  // DIV and REM treat their operands as two's-complement values.
  function automatic logic is_signed_op(input logic [1:0] op);
    return !op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit
// per clock, XLEN iterations per operation.
// Optional build macro: DIV_EARLY_OUT_EN -- divide-by-zero and signed
// overflow skip the iterations and finish one edge after acceptance.
//
// Handshake: start is sampled only while busy=0 (IDLE); the edge that sees
// start=1 in IDLE (and flush=0) accepts the operands and op, and busy rises
// from that edge. busy stays high through the single DONE cycle, in which
// done=1 and result carries the answer. result then holds until the next
// operation completes. flush returns to IDLE at any edge with no done pulse
// and leaves result untouched.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       div_op,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output div_state_e       fsm_state
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state, state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  rem, quo, dvsr, dvnd_raw;
  logic             is_rem, neg_q, neg_r, div_zero;

  logic             accept, last_iter, ovf_hit;
  logic             sgn_op, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    shifted, diff;
  logic [XLEN-1:0]  rem_next, quo_next, q_fix, r_fix, final_res;

  assign accept    = (state == S_IDLE) && start && !flush;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  // Operand magnitudes for the unsigned core; sign handling is reapplied at the end.
  always_comb begin
    sgn_op = is_signed_op(div_op);
    a_neg  = sgn_op && dividend[XLEN-1];
    b_neg  = sgn_op && divisor[XLEN-1];
    a_mag  = a_neg ? (0 - dividend) : dividend;
    b_mag  = b_neg ? (0 - divisor)  : divisor;
  end

`ifdef DIV_EARLY_OUT_EN
  logic early, ovf;
  logic ovf_in;

  assign ovf_in = is_signed_op(div_op) && (dividend == MOST_NEG) && (&divisor);

  // Flag special cases at acceptance so COMPUTE can exit after one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      early <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      early <= (divisor == '0) || ovf_in;
      ovf   <= ovf_in;
    end
  end

  assign last_iter = early || (count == LAST_CNT);
  assign ovf_hit   = ovf;
`else
  // Special cases run the full iteration count; overflow falls out naturally.
  assign last_iter = (count == LAST_CNT);
  assign ovf_hit   = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

  // Final answer: sign fix-up, then divide-by-zero and overflow overrides.
  always_comb begin
    q_fix = neg_q ? (0 - quo_next) : quo_next;
    r_fix = neg_r ? (0 - rem_next) : rem_next;
    if (div_zero) begin
      final_res = is_rem ? dvnd_raw : '1;
    end else if (ovf_hit) begin
      final_res = is_rem ? '0 : MOST_NEG;
    end else begin
      final_res = is_rem ? r_fix : q_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; flush overrides every transition including acceptance.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start)     state_next = S_COMPUTE;
      S_COMPUTE: if (last_iter) state_next = S_DONE;
      S_DONE:                   state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Datapath: capture on accept, iterate in COMPUTE, load result entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      dvnd_raw <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      count    <= '0;
      rem      <= '0;
      quo      <= a_mag;
      dvsr     <= b_mag;
      dvnd_raw <= dividend;
      is_rem   <= is_rem_op(div_op);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= (divisor == '0);
    end else if ((state == S_COMPUTE) && !flush) begin
      count <= count + 1'b1;
      rem   <= rem_next;
      quo   <= quo_next;
      if (last_iter) result <= final_res;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (XLEN=32): driver tasks push expected results
// and latencies; a negedge monitor pops and compares on every done pulse.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int FULL_LAT = XLEN;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [1:0]       div_op;
  logic [XLEN-1:0]  dividend;
  logic [XLEN-1:0]  divisor;
  logic             flush;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  div_state_e       fsm_state;

  div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              acc_q[$];
  int              checks = 0;
  int              failures = 0;
  int              last_acc = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == '0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return FULL_LAT;
  endfunction

  // monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: result 0x%08h with nothing expected", result);
      end else begin
        logic [XLEN-1:0] e;
        int l, a;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check("result", result, e);
        check("latency", XLEN'(cyc - a), XLEN'(l));
        check("busy_in_done", {31'b0, busy}, 32'd1);
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic start_raw(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    wait_idle();
    div_op   = op;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    last_acc = cyc;
    check("accept_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp);
    start_raw(op, a, b);
    exp_q.push_back(exp);
    lat_q.push_back(exp_latency(op, a, b));
    acc_q.push_back(last_acc);
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[] = '{
    '{OP_DIVU, 32'd100,         32'd7,           32'd14},
    '{OP_REMU, 32'd100,         32'd7,           32'd2},
    '{OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD},
    '{OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF},
    '{OP_DIV,  32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD},
    '{OP_REM,  32'd7,           32'hFFFF_FFFE,   32'd1},
    '{OP_DIV,  32'hFFFF_FFF8,   32'hFFFF_FFFE,   32'd4},
    '{OP_DIVU, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF},
    '{OP_REMU, 32'hFFFF_FFFF,   32'h10,          32'hF},
    '{OP_DIV,  32'd5,           32'd0,           32'hFFFF_FFFF},
    '{OP_REM,  32'd5,           32'd0,           32'd5},
    '{OP_DIVU, 32'd5,           32'd0,           32'hFFFF_FFFF},
    '{OP_REMU, 32'd5,           32'd0,           32'd5},
    '{OP_REM,  32'hFFFF_FFFF,   32'd0,           32'hFFFF_FFFF},
    '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000},
    '{OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0},
    '{OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0}
  };

  initial begin
    int t1;
    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    div_op   = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state",  {30'b0, fsm_state}, {30'b0, S_IDLE});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // directed vectors, issued back-to-back
    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start pulsed at iteration 5 must be ignored
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (5) @(posedge clk);
    #1;
    div_op   = OP_REMU;
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // flush at iteration 10: no done, result keeps 14
    start_raw(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",   {31'b0, busy}, 32'd0);
    check("flush_done",   {31'b0, done}, 32'd0);
    check("flush_result", result, 32'd14);
    repeat (40) @(negedge clk);
    check("flush_result_hold", result, 32'd14);

    // reset mid-COMPUTE
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2);
    wait_idle();
    start_raw(OP_DIV, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_busy",   {31'b0, busy}, 32'd0);
    check("midreset_done",   {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postreset_state", {30'b0, fsm_state}, {30'b0, S_IDLE});

    // back-to-back accept in the cycle right after DONE
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14);
    t1 = last_acc;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check("b2b_spacing", XLEN'(last_acc - t1), XLEN'(FULL_LAT + 2));

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending_expected", XLEN'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32 (`XLEN from rv_config.vh), datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only when busy=0.
REQ-005 SHALL have port div_op, input, 2, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend, input, XLEN, operand A; captured on the accepting edge.
REQ-007 SHALL have port divisor, input, XLEN, operand B; captured on the accepting edge.
REQ-008 SHALL have port flush, input, 1, abort any operation in progress.
REQ-009 SHALL have port busy, output, 1, high from the accepting edge until the edge leaving DONE.
REQ-010 SHALL have port done, output, 1, single-cycle pulse; result valid in that cycle.
REQ-011 SHALL have port result, output, XLEN, quotient or remainder; held stable until the next accept.

Function
REQ-012 SHALL implement states IDLE, COMPUTE, DONE: IDLE->COMPUTE on start&!busy; COMPUTE->DONE after the last iteration; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL ignore start while busy=1; operands and op are not re-captured.
REQ-014 SHALL perform radix-2 restoring division on operand magnitudes, one quotient bit per edge, XLEN iterations.
REQ-015 SHALL assert done in the cycle after the XLEN-th edge following the accepting edge; busy=1 in that cycle.
REQ-016 SHALL, for DIV/REM, negate the quotient when the operand signs differ and give the remainder the sign of the dividend.
REQ-017 SHALL, on divisor=0, return all-ones for DIV/DIVU and the unmodified dividend for REM/REMU.
REQ-018 SHALL, on signed overflow (dividend=most-negative, divisor=-1), return the most-negative value for DIV and 0 for REM.
REQ-019 SHALL, on flush=1 at any edge, go to IDLE with busy=0 and no done pulse; flush has priority over start in the same cycle.
REQ-020 SHALL accept a new start in the cycle immediately after DONE (IDLE); back-to-back throughput is one op per XLEN+2 cycles.
REQ-021 SHALL leave result unchanged on flush; result updates only on entry to DONE.

Reset
REQ-022 SHALL, while reset_n=0, force state IDLE, busy=0, done=0, result=0, and clear the iteration counter and internal registers.
REQ-023 SHALL abandon an in-flight operation on reset with no done pulse after release.

Configuration
REQ-024 SHALL, with DIV_EARLY_OUT_EN defined, detect divide-by-zero and signed overflow at the accepting edge and enter DONE on the next edge (done one cycle after accept).
REQ-025 SHALL, without DIV_EARLY_OUT_EN, run special cases through the full XLEN iterations with identical final results and latency per REQ-015.

Structure
REQ-026 SHALL take div_op encodings and state encodings from a shared package/header (rv_config.vh family) that the decoder also uses.
REQ-027 SHALL be a single module with no sub-modules; the iteration counter width is $clog2(XLEN)+1.

Verification
REQ-028 SHALL cover DIVU 100/7 with XLEN=32 -> done exactly 32 edges after accept, result=14; REMU same -> 2.
REQ-029 SHALL cover DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1).
REQ-030 SHALL cover DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; with DIV_EARLY_OUT_EN, done one edge after accept.
REQ-031 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 SHALL cover flush at iteration 10 -> busy=0 next cycle, no done, result holds the prior value; a start pulsed at iteration 5 -> ignored.
REQ-033 SHALL cover reset_n low mid-COMPUTE -> immediate busy=0, done=0, result=0; back-to-back start in the cycle after DONE is accepted.
